// File: rtl/vga_timing_out.sv
// ============================================================================
// Module   : vga_timing_out
// Purpose  : VGA raster counters, sync/blank delay line matched to the pixel
//            compositor latency, and registered pin outputs. Optional colour-bar
//            test pattern enabled by defining VGA_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_out #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [11:0] pixel_in,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0]  V_TICK_PREV  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int DW = 14;
    localparam int BAND_W = H_ACTIVE / 8;
`else
    localparam int DW = 3;
`endif

    logic          hs_raw;
    logic          vs_raw;
    logic          act_raw;
    logic [DW-1:0] raw_word;
    logic [DW-1:0] dly_word;
    logic          hs_d;
    logic          vs_d;
    logic          act_d;
    logic [11:0]   rgb_next;
    logic          line_end;

    assign line_end = (hcount == H_LAST);

    // Raster counters; frame_tick fires on the edge that lands on (0, V_ACTIVE)
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount     <= '0;
            vcount     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_ce && line_end && (vcount == V_TICK_PREV);
            if (pix_ce) begin
                if (line_end) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 11'd1;
                end
            end
        end
    end

    assign hs_raw  = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
    assign vs_raw  = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);
    assign act_raw = (hcount < H_ACT) && (vcount < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
    assign raw_word = {hcount, hs_raw, vs_raw, act_raw};
`else
    assign raw_word = {hs_raw, vs_raw, act_raw};
`endif

    generate
        if (PIPE_LAT == 0) begin : g_direct
            assign dly_word = raw_word;
        end else begin : g_pipe
            logic [DW-1:0] stages [PIPE_LAT];

            // All-zero word means blanked with both syncs inactive
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        stages[i] <= '0;
                    end
                end else if (pix_ce) begin
                    stages[0] <= raw_word;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dly_word = stages[PIPE_LAT-1];
        end
    endgenerate

    assign hs_d  = dly_word[2];
    assign vs_d  = dly_word[1];
    assign act_d = dly_word[0];

`ifdef VGA_TEST_PATTERN_EN
    logic [10:0] hcount_d;
    logic [2:0]  band_idx;

    assign hcount_d = dly_word[13:3];
    assign band_idx = 3'(hcount_d / 11'(BAND_W));

    always_comb begin
        rgb_next = 12'h000;
        if (act_d) begin
            rgb_next = test_mode ? {{4{band_idx[2]}}, {4{band_idx[1]}}, {4{band_idx[0]}}}
                                 : pixel_in;
        end
    end
`else
    always_comb begin
        rgb_next = 12'h000;
        if (act_d) begin
            rgb_next = pixel_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_ce) begin
            hsync <= hs_d ? HS_POL : ~HS_POL;
            vsync <= vs_d ? VS_POL : ~VS_POL;
            {vga_r, vga_g, vga_b} <= rgb_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_out.sv
// ============================================================================
// Module   : tb_vga_timing_out
// Purpose  : Self-checking bench for vga_timing_out on a 14x8 raster with
//            PIPE_LAT=2, checked against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_out;

    localparam int HT    = 14;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic        test_mode = 1'b0;
    logic [11:0] pixel_in = 12'h000;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        frame_tick;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: enabled edges since reset, last sampled inputs, tick flag
    int          m = 0;
    logic [11:0] last_pix = 12'h000;
    logic        last_tm = 1'b0;
    logic        exp_tick = 1'b0;

    vga_timing_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .pixel_in  (pixel_in),
        .hcount    (hcount),
        .vcount    (vcount),
        .frame_tick(frame_tick),
        .hsync     (hsync),
        .vsync     (vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] dut_vec();
        return {hcount, vcount, frame_tick, hsync, vsync, vga_r, vga_g, vga_b};
    endfunction

    // Pins after m enabled edges show raster position m-3 and the pixel of edge m
    function automatic logic [36:0] model_vec();
        logic [10:0] ch;
        logic [9:0]  cv;
        int          q, h, v;
        logic        hs, vs, act;
        logic [11:0] rgb;
        logic [2:0]  band;
        ch = 11'(m % HT);
        cv = 10'((m / HT) % VT);
        if (m < LAT) return {ch, cv, exp_tick, 1'b0, 1'b0, 12'h000};
        q   = m - LAT;
        h   = q % HT;
        v   = (q / HT) % VT;
        hs  = (h >= 10) && (h < 13);
        vs  = (v >= 5) && (v < 7);
        act = (h < 8) && (v < 4);
        band = 3'(h);
        rgb = 12'h000;
        if (act) rgb = last_tm ? {{4{band[2]}}, {4{band[1]}}, {4{band[0]}}} : last_pix;
        return {ch, cv, exp_tick, hs, vs, rgb};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m = 0;
            exp_tick = 1'b0;
        end else if (pix_ce) begin
            m = m + 1;
            last_pix = pixel_in;
            last_tm  = test_mode;
            exp_tick = ((m % FRAME) == 4 * HT);
        end else begin
            exp_tick = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_ce = 1'b1; pixel_in = 12'hFFF;
        step();
        step();
        n_checks++;
        if (dut_vec() !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 37'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_counters();
        int ticks = 0;
        logic [36:0] e;
        pix_ce = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            pixel_in = 12'($urandom);
            step();
            e = model_vec();
            if (frame_tick === 1'b1) ticks++;
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL counters cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
        n_checks++;
        if (ticks !== 2) begin
            n_fail++;
            $display("FAIL counters_ticks: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_const_pixel();
        int hits = 0;
        int hs_cyc = 0;
        int vs_cyc = 0;
        logic [36:0] e;
        pix_ce = 1'b1; pixel_in = 12'hABC;
        for (int i = 0; i < FRAME; i++) begin
            step();
            e = model_vec();
            if ({vga_r, vga_g, vga_b} === 12'hABC) hits++;
            if (hsync === 1'b1) hs_cyc++;
            if (vsync === 1'b1) vs_cyc++;
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL const_pixel cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
        n_checks++;
        if (hits !== 32) begin
            n_fail++;
            $display("FAIL const_pixel_count: got %0d expected 32", hits);
        end
        n_checks++;
        if (hs_cyc !== 3 * VT || vs_cyc !== 2 * HT) begin
            n_fail++;
            $display("FAIL sync_widths: got hs %0d vs %0d expected %0d %0d", hs_cyc, vs_cyc, 3 * VT, 2 * HT);
        end
    endtask

    task automatic test_sparse_ce();
        int ticks = 0;
        logic [36:0] e;
        for (int i = 0; i < 4 * FRAME + 8; i++) begin
            pix_ce = ((i % 4) == 0);
            pixel_in = 12'($urandom);
            step();
            e = model_vec();
            if (frame_tick === 1'b1) ticks++;
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL sparse_ce cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
        n_checks++;
        if (ticks !== 1) begin
            n_fail++;
            $display("FAIL sparse_ce_ticks: got %0d expected 1", ticks);
        end
    endtask

    task automatic test_random_ce();
        logic [36:0] e;
        for (int i = 0; i < 3 * FRAME; i++) begin
            pix_ce = ($urandom_range(0, 2) != 0);
            pixel_in = 12'($urandom);
            step();
            e = model_vec();
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL random_ce cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        logic [36:0] e;
        pix_ce = 1'b1; pixel_in = 12'h5A5;
        // Run into the vertical sync region so a reset also cuts vsync
        while (!(hcount == 11'd11 && vcount == 10'd5) && budget < 2 * FRAME) begin
            step();
            budget++;
        end
        n_checks++;
        if (budget >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL mid_reset_wait: got timeout expected hcount 11");
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (dut_vec() !== 37'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got %h expected %h", dut_vec(), 37'h0);
        end
        for (int i = 0; i < 2 * HT; i++) begin
            step();
            e = model_vec();
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL mid_reset_after cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [36:0] e;
        pix_ce = 1'b1; test_mode = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            pixel_in = 12'($urandom);
            step();
            e = model_vec();
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL test_pattern cyc %0d: got %h expected %h", i, dut_vec(), e);
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_counters();
        test_const_pixel();
        test_sparse_ce();
        test_random_ce();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
